dot_product_engine: RTL
=======================

Name: dot_product_engine

Overview:
AXI-style master that computes the dot product of two unsigned byte vectors held in the team's byte-wide AXI memory slave. It issues single-beat reads for A[i] and B[i], accumulates A[i]*B[i], and writes the result back to memory as little-endian bytes. It is the stage directly upstream of the memory, driving its AW/W/B/AR/R channels one-to-one.

Parameters:
ADDR_WIDTH, 32, address width; matches the memory slave.
DATA_WIDTH, 8, bus data width; matches the memory slave.
LEN_WIDTH, 16, width of the element-count input.
ACC_WIDTH, 32, accumulator/result width; must be a multiple of DATA_WIDTH and at least 2*DATA_WIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
base_a  in  ADDR_WIDTH  vector A base address
base_b  in  ADDR_WIDTH  vector B base address
base_c  in  ADDR_WIDTH  result base address
len  in  LEN_WIDTH  number of elements
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at completion
result  out  ACC_WIDTH  final accumulator; holds its value until the next accepted start
awaddr  out  ADDR_WIDTH, awvalid  out  1, awready  in  1  write address channel
wdata  out  DATA_WIDTH, wvalid  out  1, wready  in  1  write data channel
bvalid  in  1, bready  out  1  write response channel
araddr  out  ADDR_WIDTH, arvalid  out  1, arready  in  1  read address channel
rdata  in  DATA_WIDTH, rvalid  in  1, rready  out  1  read data channel

Behaviour:
- Reset: one clock (clk); reset rst_n is synchronous, active-low. While rst_n is low, all outputs are 0 (busy, done, result, all valids/readies, addresses, wdata), the FSM is in IDLE, and the accumulator and counters are cleared. Reset mid-operation abandons the job; no resumption.
- Accept: in IDLE, start=1 latches base_a, base_b, base_c and len, and clears acc, idx and byte_cnt. start is ignored in every other state.
- FSM: IDLE -> RD_A -> RD_B -> MAC -> (RD_A while idx<len, else WR) -> WR_RESP -> (WR while byte_cnt<ACC_WIDTH/DATA_WIDTH, else DONE) -> IDLE. With len=0, IDLE goes straight to WR.
- RD_A/RD_B:
  - Drive araddr = base + idx, modulo 2^ADDR_WIDTH, and assert arvalid.
  - Deassert arvalid in the cycle after arvalid&arready.
  - araddr stays stable from arvalid assertion until the R handshake, because the slave samples the address after AR completes.
  - rready is high while waiting in the state. Capture rdata on rvalid&rready.
- MAC: acc <= acc + zero-extend(a*b), where the product is 2*DATA_WIDTH bits. The sum wraps modulo 2^ACC_WIDTH. Then idx <= idx+1.
- WR:
  - awaddr = base_c + byte_cnt, modulo 2^ADDR_WIDTH.
  - wdata = acc[byte_cnt*DATA_WIDTH +: DATA_WIDTH], i.e. little-endian byte order.
  - Assert awvalid and wvalid together. Drop each independently in the cycle after its own handshake.
  - awaddr and wdata stay stable until the B handshake.
- WR_RESP:
  - bready = 1 only when in WR_RESP and bvalid=1; bready is combinational from bvalid. It is never asserted early.
  - On bvalid&bready, byte_cnt <= byte_cnt+1.
- DONE: result <= acc, done=1 for exactly one cycle, busy=0 in the same cycle; next state IDLE. A start in the cycle after done is accepted.
- Ordering: at most one outstanding transaction at any time. Reads and writes never overlap. Element order is A[0],B[0],A[1],B[1],...
- Latency with the companion memory (1-cycle ready): at most 8 cycles per element plus at most 5 cycles per result byte. Benches use len*8 + 5*ACC_WIDTH/DATA_WIDTH + 4 as the timeout.

Decomposition:
- Package dpa_pkg holds:
  - the FSM state enum dpa_state_t (IDLE, RD_A, RD_B, MAC, WR, WR_RESP, DONE);
  - the default width localparams;
  - the function bytes_per_result(ACC_WIDTH, DATA_WIDTH).
- One sub-module, dpa_mac: registered multiply-accumulate with clear and enable inputs, a DATA_WIDTH x DATA_WIDTH operand pair and an ACC_WIDTH accumulator output. It uses the same synchronous active-low reset.

Test Plan:
- Basic: memory preloaded with A = 01,02,03 at 0 and B = 04,05,06 at 256; base_c=512, len=3 -> result = 32'h20, done pulses once, mem[512..515] = 20,00,00,00. Read sequence is 0,256,1,257,2,258.
- len=0: base_c=600 -> no AR issued, result=0, four writes of 00 to 600..603, done pulses.
- Overflow with ACC_WIDTH=16: A = FF,FF and B = FF,FF, len=2 -> result = 16'hFC02 (0x1FC02 wrapped), mem = 02,FC.
- Backpressure: slave inserts 0-5 random cycles of delay on arready/rvalid/awready/wready/bvalid -> araddr/awaddr/wdata never change while the transaction is pending, bready never high without bvalid, and the result matches the Basic case.
- Start while busy: pulse start with different bases 10 cycles into the Basic job -> ignored; result and written bytes identical to Basic.
- Reset mid-op: assert rst_n=0 for 1 cycle during an RD_B wait -> next cycle busy=0, done=0, result=0, all valids=0. A fresh Basic job then completes correctly.

Source files
------------

// File: rtl/dpa_pkg.sv
// Shared types and default widths for the dot-product engine.
package dpa_pkg;

    localparam int DPA_ADDR_WIDTH = 32;
    localparam int DPA_DATA_WIDTH = 8;
    localparam int DPA_LEN_WIDTH  = 16;
    localparam int DPA_ACC_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        MAC,
        WR,
        WR_RESP,
        DONE
    } dpa_state_t;

    function automatic int bytes_per_result(input int acc_width, input int data_width);
        return acc_width / data_width;
    endfunction

endpackage

// File: rtl/dpa_mac.sv
// Registered multiply-accumulate: acc wraps modulo 2^ACC_WIDTH.
module dpa_mac
    import dpa_pkg::*;
#(
    parameter int DATA_WIDTH = DPA_DATA_WIDTH,
    parameter int ACC_WIDTH  = DPA_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] product;

    assign product = a * b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// AXI-style master: reads A[i]/B[i] byte pairs, accumulates their products
// and writes the accumulator back little-endian, one transaction at a time.
module dot_product_engine
    import dpa_pkg::*;
#(
    parameter int ADDR_WIDTH = DPA_ADDR_WIDTH,
    parameter int DATA_WIDTH = DPA_DATA_WIDTH,
    parameter int LEN_WIDTH  = DPA_LEN_WIDTH,
    parameter int ACC_WIDTH  = DPA_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [ADDR_WIDTH-1:0] base_c,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int NBYTES = bytes_per_result(ACC_WIDTH, DATA_WIDTH);
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam int BSW    = $clog2(NBYTES);

    dpa_state_t            state_reg;
    logic [ADDR_WIDTH-1:0] base_a_reg, base_b_reg, base_c_reg;
    logic [LEN_WIDTH-1:0]  len_reg, idx_reg;
    logic [BCW-1:0]        byte_cnt_reg;
    logic [DATA_WIDTH-1:0] a_reg, b_reg;
    logic                  wr_phase_reg;
    logic [ACC_WIDTH-1:0]  acc;

    logic [LEN_WIDTH:0]    idx_next;
    logic [BCW-1:0]        byte_cnt_next;
    logic [BSW-1:0]        byte_sel;
    logic                  r_hs;
    logic                  mac_clr, mac_en;
    logic [DATA_WIDTH-1:0] acc_bytes [NBYTES];

    assign idx_next      = {1'b0, idx_reg} + (LEN_WIDTH+1)'(1);
    assign byte_cnt_next = byte_cnt_reg + BCW'(1);
    assign byte_sel      = byte_cnt_reg[BSW-1:0];
    assign r_hs          = rvalid && rready;
    assign mac_clr       = (state_reg == IDLE) && start;
    assign mac_en        = (state_reg == MAC);

    dpa_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (a_reg),
        .b     (b_reg),
        .acc   (acc)
    );

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign acc_bytes[gi] = acc[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // wdata is taken straight from acc so the byte just updated by MAC is
    // available on the first WR cycle; acc and byte_cnt are frozen while writing.
    assign wdata  = wr_phase_reg ? acc_bytes[byte_sel] : '0;
    assign bready = (state_reg == WR_RESP) && bvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            base_a_reg   <= '0;
            base_b_reg   <= '0;
            base_c_reg   <= '0;
            len_reg      <= '0;
            idx_reg      <= '0;
            byte_cnt_reg <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            wr_phase_reg <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            awaddr       <= '0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            araddr       <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_a_reg   <= base_a;
                        base_b_reg   <= base_b;
                        base_c_reg   <= base_c;
                        len_reg      <= len;
                        idx_reg      <= '0;
                        byte_cnt_reg <= '0;
                        busy         <= 1'b1;
                        if (len == '0) begin
                            state_reg    <= WR;
                            awaddr       <= base_c;
                            awvalid      <= 1'b1;
                            wvalid       <= 1'b1;
                            wr_phase_reg <= 1'b1;
                        end else begin
                            state_reg <= RD_A;
                            araddr    <= base_a;
                            arvalid   <= 1'b1;
                            rready    <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                    end
                    if (r_hs) begin
                        a_reg     <= rdata;
                        state_reg <= RD_B;
                        araddr    <= base_b_reg + ADDR_WIDTH'(idx_reg);
                        arvalid   <= 1'b1;
                    end
                end
                RD_B: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                    end
                    if (r_hs) begin
                        b_reg     <= rdata;
                        rready    <= 1'b0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    idx_reg <= idx_next[LEN_WIDTH-1:0];
                    if (idx_next < {1'b0, len_reg}) begin
                        state_reg <= RD_A;
                        araddr    <= base_a_reg + ADDR_WIDTH'(idx_next[LEN_WIDTH-1:0]);
                        arvalid   <= 1'b1;
                        rready    <= 1'b1;
                    end else begin
                        state_reg    <= WR;
                        awaddr       <= base_c_reg;
                        awvalid      <= 1'b1;
                        wvalid       <= 1'b1;
                        wr_phase_reg <= 1'b1;
                    end
                end
                WR: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        state_reg <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        byte_cnt_reg <= byte_cnt_next;
                        if (byte_cnt_next < BCW'(NBYTES)) begin
                            state_reg <= WR;
                            awaddr    <= base_c_reg + ADDR_WIDTH'(byte_cnt_next);
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                        end else begin
                            state_reg    <= DONE;
                            result       <= acc;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            wr_phase_reg <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
